// File: rtl/datapath_gen2_if.sv
// Control, status and memory-handshake bundle for datapath_gen2.
// The slave modport is the datapath; the master modport is its sequencer/memory side.
interface datapath_gen2_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              ab_en;
  logic [1:0]        alu_src1;
  logic [1:0]        alu_src2;
  logic [2:0]        alu_op;
  logic              res_en;
  logic              psr_en;
  logic              reg_we;
  logic [1:0]        wb_sel;
  logic              pc_en;
  logic [1:0]        pc_src;
  logic              mem_start;
  logic [1:0]        mem_kind;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_err;
  logic [15:0]       instr;
  logic [WIDTH-1:0]  pc;
  logic [4:0]        psr;
  logic              alu_zero;

  modport slave (
    input  ab_en, alu_src1, alu_src2, alu_op, res_en, psr_en, reg_we, wb_sel,
           pc_en, pc_src, mem_start, mem_kind, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_done, mem_err,
           instr, pc, psr, alu_zero
  );

  modport master (
    output ab_en, alu_src1, alu_src2, alu_op, res_en, psr_en, reg_we, wb_sel,
           pc_en, pc_src, mem_start, mem_kind, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_done, mem_err,
           instr, pc, psr, alu_zero
  );
endinterface

// File: rtl/datapath_gen2.sv
// Microcoded datapath: register file, A/B latches, ALU with PSR flags, PC unit
// and a two-state memory handshake FSM with ack timeout.
module datapath_gen2 #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREG     = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic           clk,
  input  logic           reset,
  datapath_gen2_if.slave bus
);

  localparam int unsigned RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned MSB    = WIDTH - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LSH = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  // architectural state
  logic [WIDTH-1:0]  r_rf [NREG];
  logic [WIDTH-1:0]  r_pc;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res;
  logic [WIDTH-1:0]  r_mdr;
  logic [15:0]       r_instr;
  logic [4:0]        r_psr;

  // memory FSM state
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_we;
  logic              r_done;
  logic              r_err;
  logic              w_start_ok;
  logic              w_ack_ok;
  logic              w_timeout;

  // datapath wires
  logic [RIDX_W-1:0] w_ra;
  logic [RIDX_W-1:0] w_rb;
  logic [WIDTH-1:0]  w_imm;
  logic [WIDTH-1:0]  w_src1;
  logic [WIDTH-1:0]  w_src2;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_diff;
  logic [4:0]        w_sh;
  logic [5:0]        w_rmag;
  logic [WIDTH-1:0]  w_lsh;
  logic [WIDTH-1:0]  w_res;
  logic              w_c;
  logic              w_f;
  logic              w_l;
  logic              w_zero;
  logic [WIDTH-1:0]  w_wb;
  logic [WIDTH-1:0]  w_pc_nxt;

  assign w_ra  = r_instr[8 +: RIDX_W];
  assign w_rb  = r_instr[0 +: RIDX_W];
  assign w_imm = {{(WIDTH-8){r_instr[7]}}, r_instr[7:0]};

  // ALU operand selection
  always_comb begin
    w_src1 = r_pc;
    case (bus.alu_src1)
      2'b00: w_src1 = r_pc;
      2'b01: w_src1 = r_a;
      2'b10: w_src1 = '0;
      2'b11: w_src1 = WIDTH'(1);
    endcase
  end

  always_comb begin
    w_src2 = r_b;
    case (bus.alu_src2)
      2'b00: w_src2 = r_b;
      2'b01: w_src2 = w_imm;
      2'b10: w_src2 = WIDTH'(1);
      2'b11: w_src2 = '0;
    endcase
  end

  // Extended add/sub so the top bit is carry-out or borrow respectively
  assign w_sum  = {1'b0, w_src1} + {1'b0, w_src2};
  assign w_diff = {1'b0, w_src1} - {1'b0, w_src2};

  // Shift amount is a signed 5-bit field; negative values shift right logically
  assign w_sh   = w_src2[4:0];
  assign w_rmag = 6'd32 - {1'b0, w_sh};

  always_comb begin
    w_lsh = '0;
    if (!w_sh[4]) begin
      w_lsh = w_src1 << w_sh;
    end else if (32'(w_rmag) < WIDTH) begin
      w_lsh = w_src1 >> w_rmag;
    end
  end

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_f   = 1'b0;
    w_l   = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_f   = (w_src1[MSB] == w_src2[MSB]) && (w_sum[MSB] != w_src1[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_f   = (w_src1[MSB] != w_src2[MSB]) && (w_diff[MSB] != w_src1[MSB]);
        w_l   = (bus.alu_op == OP_CMP) && w_diff[WIDTH];
      end
      OP_AND: w_res = w_src1 & w_src2;
      OP_OR:  w_res = w_src1 | w_src2;
      OP_XOR: w_res = w_src1 ^ w_src2;
      OP_MOV: w_res = w_src2;
      OP_LSH: w_res = w_lsh;
    endcase
  end

  assign w_zero = (w_res == '0);

  always_comb begin
    w_wb = r_res;
    case (bus.wb_sel)
      2'b00: w_wb = r_res;
      2'b01: w_wb = r_mdr;
      2'b10: w_wb = r_pc;
      2'b11: w_wb = r_b;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc + WIDTH'(1);
    case (bus.pc_src)
      2'b00: w_pc_nxt = r_pc + WIDTH'(1);
      2'b01: w_pc_nxt = r_b;
      2'b10: w_pc_nxt = r_pc + w_imm;
      2'b11: w_pc_nxt = '0;
    endcase
  end

  // Register file has no reset; reads see the pre-write value in the write cycle
  always_ff @(posedge clk) begin
    if (bus.reg_we) begin
      r_rf[w_ra] <= w_wb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_mdr   <= '0;
      r_instr <= '0;
      r_psr   <= '0;
    end else begin
      if (bus.ab_en) begin
        r_a <= r_rf[w_ra];
        r_b <= r_rf[w_rb];
      end
      if (bus.res_en && (bus.alu_op != OP_CMP)) begin
        r_res <= w_res;
      end
      if (bus.psr_en) begin
        r_psr <= {w_res[MSB], w_zero, w_f, w_l, w_c};
      end
      if (bus.pc_en) begin
        r_pc <= w_pc_nxt;
      end
      if (w_ack_ok && (r_kind == K_FETCH)) begin
        r_instr <= bus.mem_rdata[15:0];
      end
      if (w_ack_ok && (r_kind == K_LOAD)) begin
        r_mdr <= bus.mem_rdata;
      end
    end
  end

  // Memory FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; an ack on the final wait cycle wins over the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_ack_ok    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_start && (bus.mem_kind != 2'b11)) begin
          w_state_nxt = S_REQ;
          w_start_ok  = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          w_state_nxt = S_IDLE;
          w_ack_ok    = 1'b1;
        end else if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
    endcase
  end

  // Transaction attributes captured at request entry and held until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait  <= '0;
      r_kind  <= K_FETCH;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_ack_ok;
      r_err  <= w_timeout;
      if (w_start_ok) begin
        r_wait  <= '0;
        r_kind  <= bus.mem_kind;
        r_addr  <= (bus.mem_kind == K_FETCH) ? r_pc[ADDR_W-1:0] : r_b[ADDR_W-1:0];
        r_wdata <= r_a;
        r_we    <= (bus.mem_kind == K_STORE);
      end else if (r_state == S_REQ) begin
        if (!bus.mem_ack) begin
          r_wait <= r_wait + WAIT_W'(1);
        end
        if (w_state_nxt == S_IDLE) begin
          r_we <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_req   = (r_state == S_REQ);
  assign bus.mem_busy  = (r_state != S_IDLE);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_done  = r_done;
  assign bus.mem_err   = r_err;
  assign bus.instr     = r_instr;
  assign bus.pc        = r_pc;
  assign bus.psr       = r_psr;
  assign bus.alu_zero  = w_zero;

endmodule

// File: doc/datapath_gen2.md
DATAPATH_GEN2 -- requirements
Module: datapath_gen2

Interface
REQ-001 Parameter: WIDTH, 16, data/register/PC width in bits; legal range 16..32.
REQ-002 Parameter: NREG, 16, register count; power of two, 2..16; register index = low log2(NREG) bits of the instruction field.
REQ-003 Parameter: ADDR_W, 16, memory address width; legal range ADDR_W <= WIDTH; address = low ADDR_W bits of the source value.
REQ-004 Parameter: MAX_WAIT, 15, maximum number of cycles to wait for mem_ack before timeout; legal range >= 1.
REQ-005 Ports, in order:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- ab_en  in  1  latch A=RF[instr[11:8]] and B=RF[instr[3:0]].
- alu_src1  in  2  00 PC, 01 A, 10 zero, 11 one.
- alu_src2  in  2  00 B, 01 IMM, 10 one, 11 zero.
- alu_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV(src2), 110 LSH, 111 CMP.
- res_en  in  1  latch ALU result into RES.
- psr_en  in  1  latch flags into PSR.
- reg_we  in  1  write writeback data to RF[instr[11:8]].
- wb_sel  in  2  writeback data: 00 RES, 01 MDR, 10 PC, 11 B.
- pc_en  in  1  load PC.
- pc_src  in  2  next PC: 00 PC+1, 01 B, 10 PC+IMM, 11 zero.
- mem_start  in  1  start a memory transaction.
- mem_kind  in  2  00 fetch, 01 load, 10 store; 11 is ignored.
- mem_rdata  in  WIDTH  read data.
- mem_ack  in  1  memory completion strobe.
- mem_req  out  1  transaction request.
- mem_we  out  1  store request.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WIDTH  store data.
- mem_busy  out  1  memory FSM not IDLE.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle timeout pulse.
- instr  out  16  instruction register.
- pc  out  WIDTH  program counter.
- psr  out  5  flags {N,Z,F,L,C}.
- alu_zero  out  1  combinational ALU result == 0.

Function
REQ-006 IMM SHALL be instr[7:0] sign-extended to WIDTH.
REQ-007 ADD/SUB/CMP: C = carry-out (ADD) or borrow (SUB/CMP); F = signed overflow; L = unsigned src1<src2 (CMP only, else 0); Z = result==0; N = result MSB. Logic ops, MOV and LSH SHALL clear C, F and L.
REQ-008 CMP SHALL compute src1-src2; RES SHALL be unchanged by CMP even when res_en=1.
REQ-009 LSH: signed shift of src1 by src2[4:0]; positive = left, negative = right logical; |shift| >= WIDTH yields 0.
REQ-010 RF reads SHALL be combinational; writes SHALL be synchronous; a same-cycle read of the register being written SHALL return the old value.
REQ-011 PC arithmetic SHALL wrap modulo 2^WIDTH.
REQ-012 Memory FSM states and transitions:
- IDLE -> REQ on mem_start with legal mem_kind.
- REQ -> IDLE on mem_ack.
- REQ -> IDLE on timeout.
REQ-013 On the IDLE->REQ edge, mem_addr SHALL latch PC (fetch) or B (load/store), and mem_wdata SHALL latch A.
REQ-014 mem_addr, mem_wdata and mem_we SHALL be held stable throughout REQ.
REQ-015 mem_req SHALL equal (state==REQ). mem_we SHALL be 1 only in REQ for a store.
REQ-016 On mem_ack in REQ: a fetch SHALL load instr with mem_rdata[15:0]; a load SHALL load MDR with mem_rdata; mem_done SHALL pulse on the following cycle.
REQ-017 The wait counter SHALL clear on REQ entry and increment each REQ cycle without ack. If it reaches MAX_WAIT with no ack, the FSM SHALL return to IDLE, mem_err SHALL pulse on the following cycle, and instr/MDR SHALL be unchanged.
REQ-018 mem_start while busy SHALL be ignored. mem_ack in IDLE SHALL be ignored. mem_ack in the same cycle as timeout SHALL count as success.
REQ-019 A new mem_start SHALL be accepted in the same cycle that mem_done or mem_err is high.

Reset
REQ-020 While reset is asserted, all of the following SHALL be zero and the FSM SHALL be in IDLE: PC, instr, A, B, RES, MDR, PSR, wait counter, mem_req, mem_we, mem_done, mem_err, mem_busy. mem_addr and mem_wdata SHALL also be zero.
REQ-021 Reset asserted during REQ SHALL drop mem_req asynchronously, with no done or err pulse afterwards. RF contents are undefined after reset.

Verification
REQ-022 Reset; then mem_start with fetch; ack after 3 cycles with rdata=0x1234 -> mem_req high for 3 cycles, instr=0x1234, mem_done pulses once, mem_addr=0.
REQ-023 RF[1]=0x7FFF, RF[2]=0x0001; ADD with src1=A, src2=B; res_en and psr_en -> RES=0x8000, F=1, N=1, C=0, Z=0.
REQ-024 CMP of 0x0003 vs 0x0005 -> L=1, C=1, N=1, RES unchanged.
REQ-025 Store with no ack, MAX_WAIT=15 -> mem_req high 15 cycles, then mem_err pulse, busy low. A second mem_start issued mid-wait is ignored.
REQ-026 PC=0x0005, instr[7:0]=0xFE, pc_src=10 -> PC=0x0003. PC=0xFFFF, pc_src=00 -> PC=0x0000.
REQ-027 Reset pulsed during REQ of a load -> mem_req low immediately, MDR=0, no mem_done afterwards.
